mandel_dispatcher: RTL and testbench

MANDEL_DISPATCHER -- requirements
Module: mandel_dispatcher

---
 rtl/mandel_dispatcher_pkg.sv | 30 +++
 rtl/mandel_dispatcher_coord_stepper.sv | 72 +++++++
 rtl/mandel_dispatcher.sv | 117 +++++++++++
 tb/tb_mandel_dispatcher.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_dispatcher_pkg.sv
// Shared types and helpers for the Mandelbrot frame dispatcher.
// Fixed-point c values are signed 4.23 held in 27-bit two's complement.
package mandel_dispatcher_pkg;

  localparam int unsigned FixW    = 27;
  localparam int unsigned FixFrac = 23;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitDone,
    StWrite,
    StAck,
    StFinish
  } state_e;

  // Points that hit the cap are painted black (0); 0 itself is reserved,
  // so an escape count whose low byte is 0 is nudged to 1.
  function automatic logic [7:0] colour_map(input logic [31:0] iterations,
                                            input logic [31:0] iter_max);
    if (iterations >= iter_max) begin
      return 8'h00;
    end else if (iterations[7:0] == 8'h00) begin
      return 8'h01;
    end else begin
      return iterations[7:0];
    end
  endfunction

endpackage

// File: rtl/mandel_dispatcher_coord_stepper.sv
// Walks the pixel grid in raster order, tracking x/y, the complex c for the
// current pixel and the linear write address.
module coord_stepper
  import mandel_dispatcher_pkg::*;
#(
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned V_PIXELS = 480,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init,
  input  logic            advance,
  input  logic [FixW-1:0] cr_start,
  input  logic [FixW-1:0] ci_start,
  input  logic [FixW-1:0] dr,
  input  logic [FixW-1:0] di,
  output logic [FixW-1:0] cr,
  output logic [FixW-1:0] ci,
  output logic [ADDR_W-1:0] wr_addr,
  output logic            last_pixel
);

  localparam int unsigned XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int unsigned YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
  localparam logic [XW-1:0] XLast = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] YLast = YW'(V_PIXELS - 1);

  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [FixW-1:0] cr_base_q;
  logic [FixW-1:0] dr_q;
  logic [FixW-1:0] di_q;

  assign last_pixel = (x_q == XLast) && (y_q == YLast);

  // Raster order means y*H+x simply increments by one per pixel, row wrap
  // included, so no multiplier is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q       <= '0;
      y_q       <= '0;
      cr        <= '0;
      ci        <= '0;
      cr_base_q <= '0;
      dr_q      <= '0;
      di_q      <= '0;
      wr_addr   <= '0;
    end else if (init) begin
      x_q       <= '0;
      y_q       <= '0;
      cr        <= cr_start;
      ci        <= ci_start;
      cr_base_q <= cr_start;
      dr_q      <= dr;
      di_q      <= di;
      wr_addr   <= '0;
    end else if (advance) begin
      wr_addr <= wr_addr + ADDR_W'(1);
      if (x_q == XLast) begin
        x_q <= '0;
        y_q <= y_q + YW'(1);
        cr  <= cr_base_q;
        ci  <= ci - di_q;
      end else begin
        x_q <= x_q + XW'(1);
        cr  <= cr + dr_q;
      end
    end
  end

endmodule

// File: rtl/mandel_dispatcher.sv
// Frame dispatcher: hands one pixel at a time to a Mandelbrot iterator and
// writes the colour-mapped result to pixel memory.
module mandel_dispatcher
  import mandel_dispatcher_pkg::*;
#(
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned V_PIXELS = 480,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FixW-1:0]   cr_start,
  input  logic [FixW-1:0]   ci_start,
  input  logic [FixW-1:0]   dr,
  input  logic [FixW-1:0]   di,
  input  logic [31:0]       max_iterations,
  output logic [FixW-1:0]   cr_init,
  output logic [FixW-1:0]   ci_init,
  output logic [31:0]       iter_max,
  output logic              iter_go,
  input  logic              done,
  input  logic [31:0]       iterations,
  output logic              handshake,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done
);

  state_e state_q;
  logic   init;
  logic   advance;
  logic   last_pixel;

  assign init    = (state_q == StIdle) && start;
  assign advance = (state_q == StAck);

  coord_stepper #(
    .H_PIXELS(H_PIXELS),
    .V_PIXELS(V_PIXELS),
    .ADDR_W  (ADDR_W)
  ) u_coord_stepper (
    .clk       (clk),
    .rst       (rst),
    .init      (init),
    .advance   (advance),
    .cr_start  (cr_start),
    .ci_start  (ci_start),
    .dr        (dr),
    .di        (di),
    .cr        (cr_init),
    .ci        (ci_init),
    .wr_addr   (wr_addr),
    .last_pixel(last_pixel)
  );

  // Pulse outputs are set on the transition into their state so they are
  // high for exactly the cycle the FSM spends there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      iter_max   <= '0;
      iter_go    <= 1'b0;
      handshake  <= 1'b0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            iter_max <= max_iterations;
            iter_go  <= 1'b1;
            busy     <= 1'b1;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          iter_go <= 1'b0;
          state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (done) begin
            wr_data <= colour_map(iterations, iter_max);
            wr_en   <= 1'b1;
            state_q <= StWrite;
          end
        end
        StWrite: begin
          wr_en     <= 1'b0;
          handshake <= 1'b1;
          state_q   <= StAck;
        end
        StAck: begin
          handshake <= 1'b0;
          if (last_pixel) begin
            frame_done <= 1'b1;
            state_q    <= StFinish;
          end else begin
            iter_go <= 1'b1;
            state_q <= StLoad;
          end
        end
        StFinish: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_dispatcher.sv
// Directed bench for mandel_dispatcher on a 4x2 frame with an iterator stub.
module tb_mandel_dispatcher;

  localparam int unsigned H = 4;
  localparam int unsigned V = 2;
  localparam int unsigned AW = 19;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [26:0] cr_start = '0, ci_start = '0, dr = '0, di = '0;
  logic [31:0] max_iterations = '0;
  logic [26:0] cr_init, ci_init;
  logic [31:0] iter_max;
  logic        iter_go, done, handshake, wr_en, busy, frame_done;
  logic [31:0] iterations;
  logic [AW-1:0] wr_addr;
  logic [7:0]  wr_data;

  mandel_dispatcher #(.H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cr_start      (cr_start),
    .ci_start      (ci_start),
    .dr            (dr),
    .di            (di),
    .max_iterations(max_iterations),
    .cr_init       (cr_init),
    .ci_init       (ci_init),
    .iter_max      (iter_max),
    .iter_go       (iter_go),
    .done          (done),
    .iterations    (iterations),
    .handshake     (handshake),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  // Iterator stub: done rises stub_delay cycles after iter_go, falls on handshake.
  logic        stub_const = 1'b0;
  int          stub_delay = 2;
  logic [31:0] stub_iter  = 32'd5;
  logic        pend;
  int          cnt;
  assign iterations = stub_iter;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
      pend <= 1'b0;
      cnt  <= 0;
    end else if (stub_const) begin
      done <= 1'b1;
    end else begin
      if (handshake) done <= 1'b0;
      if (iter_go) begin
        pend <= 1'b1;
        cnt  <= stub_delay;
      end else if (pend) begin
        if (cnt <= 1) begin
          done <= 1'b1;
          pend <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  int          cyc = 0;
  logic [AW-1:0] wa_q[$];
  logic [7:0]  wd_q[$];
  logic [26:0] wcr_q[$], wci_q[$];
  int          go_q[$];
  int          n_hs = 0, n_fd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      wcr_q.push_back(cr_init);
      wci_q.push_back(ci_init);
    end
    if (iter_go) go_q.push_back(cyc);
    if (handshake) n_hs = n_hs + 1;
    if (frame_done) n_fd = n_fd + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wcr_q.delete();
    wci_q.delete();
    go_q.delete();
    n_hs = 0;
    n_fd = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_log();
  endtask

  task automatic kick(input logic [26:0] crs, input logic [26:0] cis, input logic [26:0] d_r,
                      input logic [26:0] d_i, input logic [31:0] mx);
    cr_start = crs;
    ci_start = cis;
    dr = d_r;
    di = d_i;
    max_iterations = mx;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int k;
    for (k = 0; k < 500 && n_fd == 0; k++) @(negedge clk);
    if (n_fd == 0) check({tag, "_timeout"}, 64'd0, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  logic [26:0] cr_exp[4];
  logic [31:0] tab_it[6];
  logic [31:0] tab_mx[6];
  logic [7:0]  tab_wd[6];

  initial begin
    cr_exp[0] = 27'h7C00000; cr_exp[1] = 27'h7D00000;
    cr_exp[2] = 27'h7E00000; cr_exp[3] = 27'h7F00000;
    tab_it[0] = 32'd100;  tab_mx[0] = 32'd100;  tab_wd[0] = 8'h00;
    tab_it[1] = 32'd256;  tab_mx[1] = 32'd1000; tab_wd[1] = 8'h01;
    tab_it[2] = 32'd5;    tab_mx[2] = 32'd100;  tab_wd[2] = 8'h05;
    tab_it[3] = 32'd99;   tab_mx[3] = 32'd100;  tab_wd[3] = 8'h63;
    tab_it[4] = 32'd0;    tab_mx[4] = 32'd100;  tab_wd[4] = 8'h01;
    tab_it[5] = 32'd1000; tab_mx[5] = 32'd1000; tab_wd[5] = 8'h00;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_iter_go", iter_go, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_handshake", handshake, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_cr_init", cr_init, 0);
    check("rst_wr_addr", wr_addr, 0);
    do_reset();

    // Basic 4x2 frame
    stub_iter = 32'd5;
    kick(27'h7C00000, 27'h0400000, 27'h0100000, 27'h0100000, 32'd100);
    check("busy_running", busy, 1);
    wait_frame("frame");
    check("n_writes", wa_q.size(), 8);
    for (int i = 0; i < 8 && i < wa_q.size(); i++) begin
      check($sformatf("addr%0d", i), wa_q[i], i);
      check($sformatf("data%0d", i), wd_q[i], 8'h05);
      check($sformatf("cr%0d", i), wcr_q[i], cr_exp[i % 4]);
      check($sformatf("ci%0d", i), wci_q[i], (i < 4) ? 27'h0400000 : 27'h0300000);
    end
    check("n_frame_done", n_fd, 1);
    check("n_handshake", n_hs, 8);
    check("iter_max", iter_max, 100);
    check("busy_after", busy, 0);

    // Colour map
    for (int t = 0; t < 6; t++) begin
      do_reset();
      stub_iter = tab_it[t];
      kick(27'h7C00000, 27'h0400000, 27'h0100000, 27'h0100000, tab_mx[t]);
      wait_frame("cmap");
      check($sformatf("cmap%0d_n", t), wd_q.size(), 8);
      if (wd_q.size() > 0) check($sformatf("cmap%0d_data", t), wd_q[0], tab_wd[t]);
    end

    // Constant done: 4 cycles per pixel
    do_reset();
    stub_iter = 32'd5;
    stub_const = 1'b1;
    kick(27'h7C00000, 27'h0400000, 27'h0100000, 27'h0100000, 32'd100);
    wait_frame("const");
    stub_const = 1'b0;
    check("const_n_go", go_q.size(), 8);
    for (int i = 1; i < go_q.size(); i++)
      check($sformatf("pix_period%0d", i), go_q[i] - go_q[i-1], 4);

    // start during WAIT_DONE is ignored
    do_reset();
    kick(27'h7C00000, 27'h0400000, 27'h0100000, 27'h0100000, 32'd100);
    for (int k = 0; k < 100 && go_q.size() < 3; k++) @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_frame("restart");
    check("ign_n_writes", wa_q.size(), 8);
    for (int i = 0; i < wa_q.size(); i++) check($sformatf("ign_addr%0d", i), wa_q[i], i);
    check("ign_n_fd", n_fd, 1);

    // Reset during pixel 3
    do_reset();
    kick(27'h7C00000, 27'h0400000, 27'h0100000, 27'h0100000, 32'd100);
    for (int k = 0; k < 100 && go_q.size() < 3; k++) @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_iter_go", iter_go, 0);
    check("midrst_wr_en", wr_en, 0);
    check("midrst_handshake", handshake, 0);
    check("midrst_cr", cr_init, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_writes", wa_q.size(), 2);
    check("midrst_hs", n_hs, 2);
    clear_log();
    kick(27'h7C00000, 27'h0400000, 27'h0100000, 27'h0100000, 32'd100);
    wait_frame("after_rst");
    check("rerun_n", wa_q.size(), 8);
    if (wa_q.size() > 0) begin
      check("rerun_addr0", wa_q[0], 0);
      check("rerun_cr0", wcr_q[0], 27'h7C00000);
    end

    // 27-bit wrap on the cr add
    do_reset();
    kick(27'h3FFFFFF, 27'h0000000, 27'h0000001, 27'h0000001, 32'd100);
    wait_frame("wrap");
    check("wrap_n", wcr_q.size(), 8);
    if (wcr_q.size() > 1) begin
      check("wrap_cr0", wcr_q[0], 27'h3FFFFFF);
      check("wrap_cr1", wcr_q[1], 27'h4000000);
    end
    if (wci_q.size() > 4) check("wrap_ci_row1", wci_q[4], 27'h7FFFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
